mem_arbiter: RTL and testbench

Two-port arbiter that shares the single `sram` memory port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It sits between IFU/LSU and `sram`. It grants one requester at a time using round-robin under contention, and drives the memory port until `sram_valid` completes the access. It returns a one-cycle response pulse to the owner and aborts any access that exceeds a programmable timeout, flagging it as an error.

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of IFU, LSU and SRAM-side signals shared by mem_arbiter and its environment.
// The arbiter takes the slave view; the requesters and memory take the master view.
interface mem_arbiter_if;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_gnt;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        ifu_err;

  logic        lsu_req;
  logic        lsu_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_gnt;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;

  logic        mem_ren;
  logic        mem_wen;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_data;
  logic        mem_valid;

  modport slave (
    input  ifu_req, ifu_addr,
    input  lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    input  mem_data, mem_valid,
    output ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
    output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
    output mem_ren, mem_wen, mem_wmask, mem_addr, mem_wdata
  );

  modport master (
    output ifu_req, ifu_addr,
    output lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    output mem_data, mem_valid,
    input  ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
    input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
    input  mem_ren, mem_wen, mem_wmask, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one SRAM port between the IFU (read-only) and the LSU,
// with a per-access timeout that completes a stuck access with an error response.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          LSU_FIRST      = 1'b1
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_IFU, BUSY_LSU} state_t;

  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic        last_lsu;
  logic [31:0] addr_q, wdata_q;
  logic [7:0]  wmask_q;
  logic        wen_q;
  logic [15:0] cnt;
  logic        idle, busy, ifu_wins, lsu_wins, ifu_gnt, lsu_gnt;
  logic        done, timed_out;
  logic        ifu_rvalid_q, ifu_err_q, lsu_rvalid_q, lsu_err_q;
  logic [31:0] ifu_rdata_q, lsu_rdata_q;

  // Under contention the requester that was not served last wins.
  assign idle     = (state == IDLE);
  assign busy     = !idle;
  assign ifu_wins = bus.ifu_req & (!bus.lsu_req | last_lsu);
  assign lsu_wins = bus.lsu_req & (!bus.ifu_req | !last_lsu);
  assign ifu_gnt  = !rst & idle & ifu_wins;
  assign lsu_gnt  = !rst & idle & lsu_wins;

  always_comb begin
    state_next = state;
    done       = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (lsu_gnt)      state_next = BUSY_LSU;
        else if (ifu_gnt) state_next = BUSY_IFU;
      end
      BUSY_IFU, BUSY_LSU: begin
        if (bus.mem_valid) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (TIMEOUT_EN && cnt == TIMEOUT_LAST) begin
          timed_out  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A reset mid-access simply drops it: no response pulse is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_lsu     <= !LSU_FIRST;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      wen_q        <= 1'b0;
      cnt          <= '0;
      ifu_rvalid_q <= 1'b0;
      ifu_err_q    <= 1'b0;
      ifu_rdata_q  <= '0;
      lsu_rvalid_q <= 1'b0;
      lsu_err_q    <= 1'b0;
      lsu_rdata_q  <= '0;
    end else begin
      state        <= state_next;
      ifu_rvalid_q <= 1'b0;
      ifu_err_q    <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      lsu_err_q    <= 1'b0;
      if (lsu_gnt) begin
        addr_q   <= bus.lsu_addr;
        wen_q    <= bus.lsu_wen;
        wdata_q  <= bus.lsu_wdata;
        wmask_q  <= bus.lsu_wmask;
        last_lsu <= 1'b1;
        cnt      <= '0;
      end else if (ifu_gnt) begin
        addr_q   <= bus.ifu_addr;
        wen_q    <= 1'b0;
        wmask_q  <= '0;
        last_lsu <= 1'b0;
        cnt      <= '0;
      end else if (busy && !done && !timed_out && cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
      if (done || timed_out) begin
        if (state == BUSY_IFU) begin
          ifu_rvalid_q <= 1'b1;
          ifu_err_q    <= timed_out;
          ifu_rdata_q  <= done ? bus.mem_data : 32'h0;
        end else begin
          lsu_rvalid_q <= 1'b1;
          lsu_err_q    <= timed_out;
          lsu_rdata_q  <= (done && !wen_q) ? bus.mem_data : 32'h0;
        end
      end
    end
  end

  assign bus.ifu_gnt    = ifu_gnt;
  assign bus.lsu_gnt    = lsu_gnt;
  assign bus.ifu_rvalid = ifu_rvalid_q;
  assign bus.ifu_err    = ifu_err_q;
  assign bus.ifu_rdata  = ifu_rdata_q;
  assign bus.lsu_rvalid = lsu_rvalid_q;
  assign bus.lsu_err    = lsu_err_q;
  assign bus.lsu_rdata  = lsu_rdata_q;
  assign bus.mem_ren    = busy & !wen_q;
  assign bus.mem_wen    = busy & wen_q;
  assign bus.mem_wmask  = busy ? wmask_q : 8'h0;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a simple SRAM model plus per-port response
// scoreboards, with directed timing checks around grants, timeouts and reset.
module tb_mem_arbiter;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   mem_latency = 0;
  bit   mem_hang = 1'b0;
  int   busy_cnt = 0;
  resp_t ifu_exp[$];
  resp_t lsu_exp[$];

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(4), .LSU_FIRST(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic logic [31:0] read_model(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'ha5a5_0000;
  endfunction

  // SRAM model: valid arrives mem_latency cycles into an access unless hung.
  logic mem_active;
  assign mem_active    = bus.mem_ren | bus.mem_wen;
  assign bus.mem_valid = mem_active && !mem_hang && (busy_cnt == mem_latency);
  assign bus.mem_data  = bus.mem_ren ? read_model(bus.mem_addr) : 32'h0;

  always @(posedge clk) busy_cnt <= (mem_active && !bus.mem_valid) ? busy_cnt + 1 : 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr, input logic lreq,
                               input logic lwen, input logic [31:0] laddr,
                               input logic [31:0] lwdata, input logic [7:0] lmask);
    bus.ifu_req   = ireq;
    bus.ifu_addr  = iaddr;
    bus.lsu_req   = lreq;
    bus.lsu_wen   = lwen;
    bus.lsu_addr  = laddr;
    bus.lsu_wdata = lwdata;
    bus.lsu_wmask = lmask;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic resp_t mk(input logic [31:0] d, input logic e);
    resp_t r;
    r.rdata = d;
    r.err   = e;
    return r;
  endfunction

  // Scoreboard side: every response pulse must match the oldest expectation for its port.
  always @(negedge clk) begin
    resp_t e;
    if (!rst && (bus.ifu_rvalid || bus.lsu_rvalid)) begin
      checkOutput("dual_rvalid", 32'(bus.ifu_rvalid & bus.lsu_rvalid), 32'h0);
      if (bus.ifu_rvalid) begin
        if (ifu_exp.size() == 0) checkOutput("ifu_unexpected_rvalid", 32'(ifu_exp.size()), 32'h1);
        else begin
          e = ifu_exp.pop_front();
          checkOutput("ifu_rdata", bus.ifu_rdata, e.rdata);
          checkOutput("ifu_err", 32'(bus.ifu_err), 32'(e.err));
        end
      end
      if (bus.lsu_rvalid) begin
        if (lsu_exp.size() == 0) checkOutput("lsu_unexpected_rvalid", 32'(lsu_exp.size()), 32'h1);
        else begin
          e = lsu_exp.pop_front();
          checkOutput("lsu_rdata", bus.lsu_rdata, e.rdata);
          checkOutput("lsu_err", 32'(bus.lsu_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    int   grants;
    bit   outstanding;
    bit   exp_lsu;
    bit   seen;
    logic [31:0] addr;

    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 8'h0);
    repeat (3) nextCycle();
    sample();
    checkOutput("reset_gnt", {30'h0, bus.ifu_gnt, bus.lsu_gnt}, 32'h0);
    checkOutput("reset_mem", {22'h0, bus.mem_ren, bus.mem_wen, bus.mem_wmask}, 32'h0);
    checkOutput("reset_resp", {28'h0, bus.ifu_rvalid, bus.ifu_err, bus.lsu_rvalid, bus.lsu_err}, 32'h0);
    checkOutput("reset_addr", bus.mem_addr, 32'h0);

    // Contention from reset: LSU first, then strict alternation.
    nextCycle();
    rst = 1'b0;
    applyStimulus(1, 32'h0000_0100, 1, 0, 32'h0000_0200, 32'h0, 8'h0);
    grants = 0;
    outstanding = 1'b0;
    exp_lsu = 1'b1;
    for (int i = 0; i < 16 && grants < 4; i++) begin
      sample();
      if (bus.ifu_rvalid || bus.lsu_rvalid) outstanding = 1'b0;
      if (bus.ifu_gnt || bus.lsu_gnt) begin
        checkOutput("contend_single", 32'(bus.ifu_gnt & bus.lsu_gnt), 32'h0);
        checkOutput("contend_overlap", 32'(outstanding), 32'h0);
        checkOutput("contend_order", 32'(bus.lsu_gnt), 32'(exp_lsu));
        if (bus.lsu_gnt) lsu_exp.push_back(mk(read_model(32'h0000_0200), 1'b0));
        else             ifu_exp.push_back(mk(read_model(32'h0000_0100), 1'b0));
        outstanding = 1'b1;
        exp_lsu = !exp_lsu;
        grants++;
      end
      nextCycle();
    end
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 8'h0);
    checkOutput("contend_grants", 32'(grants), 32'd4);
    repeat (3) nextCycle();

    // IFU read with one cycle of memory latency.
    mem_latency = 1;
    applyStimulus(1, 32'h8000_0000, 0, 0, 32'h0, 32'h0, 8'h0);
    ifu_exp.push_back(mk(32'h0000_0413, 1'b0));
    sample();
    checkOutput("rd_t0_gnt", 32'(bus.ifu_gnt), 32'h1);
    checkOutput("rd_t0_ren", 32'(bus.mem_ren), 32'h0);
    nextCycle();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 8'h0);
    sample();
    checkOutput("rd_t1_ren", 32'(bus.mem_ren), 32'h1);
    checkOutput("rd_t1_addr", bus.mem_addr, 32'h8000_0000);
    nextCycle();
    sample();
    checkOutput("rd_t2_ren", 32'(bus.mem_ren), 32'h1);
    nextCycle();
    sample();
    checkOutput("rd_t3_ren", 32'(bus.mem_ren), 32'h0);
    checkOutput("rd_t3_rvalid", 32'(bus.ifu_rvalid), 32'h1);
    nextCycle();
    sample();
    checkOutput("rd_t4_rvalid", 32'(bus.ifu_rvalid), 32'h0);

    // LSU write completing in its first BUSY cycle.
    nextCycle();
    mem_latency = 0;
    applyStimulus(0, 32'h0, 1, 1, 32'h8000_1000, 32'hdead_beef, 8'h0f);
    lsu_exp.push_back(mk(32'h0, 1'b0));
    sample();
    checkOutput("wr_gnt", 32'(bus.lsu_gnt), 32'h1);
    nextCycle();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 8'h0);
    sample();
    checkOutput("wr_en", {30'h0, bus.mem_wen, bus.mem_ren}, 32'h2);
    checkOutput("wr_addr", bus.mem_addr, 32'h8000_1000);
    checkOutput("wr_wdata", bus.mem_wdata, 32'hdead_beef);
    checkOutput("wr_wmask", 32'(bus.mem_wmask), 32'h0f);
    nextCycle();
    sample();
    checkOutput("wr_wen_off", 32'(bus.mem_wen), 32'h0);
    checkOutput("wr_rvalid", 32'(bus.lsu_rvalid), 32'h1);

    // LSU read against a hung memory: four BUSY cycles then an error response.
    nextCycle();
    mem_hang = 1'b1;
    applyStimulus(0, 32'h0, 1, 0, 32'h8000_2000, 32'h0, 8'h0);
    lsu_exp.push_back(mk(32'h0, 1'b1));
    sample();
    checkOutput("to_gnt", 32'(bus.lsu_gnt), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      nextCycle();
      if (i == 1) applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 8'h0);
      sample();
      checkOutput("to_ren_held", 32'(bus.mem_ren), 32'h1);
    end
    nextCycle();
    sample();
    checkOutput("to_ren_off", 32'(bus.mem_ren), 32'h0);
    checkOutput("to_resp", {30'h0, bus.lsu_rvalid, bus.lsu_err}, 32'h3);
    mem_hang = 1'b0;
    nextCycle();
    applyStimulus(1, 32'h8000_0000, 0, 0, 32'h0, 32'h0, 8'h0);
    ifu_exp.push_back(mk(32'h0000_0413, 1'b0));
    sample();
    checkOutput("to_ifu_gnt", 32'(bus.ifu_gnt), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      nextCycle();
      if (i == 0) applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 8'h0);
      sample();
      seen = bus.ifu_rvalid;
    end
    checkOutput("to_ifu_resp", 32'(seen), 32'h1);

    // Reset pulsed in the second BUSY_IFU cycle drops the access.
    nextCycle();
    mem_hang = 1'b1;
    applyStimulus(1, 32'h8000_3000, 0, 0, 32'h0, 32'h0, 8'h0);
    sample();
    checkOutput("rb_gnt", 32'(bus.ifu_gnt), 32'h1);
    nextCycle();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 8'h0);
    sample();
    checkOutput("rb_busy1_ren", 32'(bus.mem_ren), 32'h1);
    nextCycle();
    rst = 1'b1;
    sample();
    nextCycle();
    rst = 1'b0;
    sample();
    checkOutput("rb_gnts", {30'h0, bus.ifu_gnt, bus.lsu_gnt}, 32'h0);
    checkOutput("rb_mem", {22'h0, bus.mem_ren, bus.mem_wen, bus.mem_wmask}, 32'h0);
    checkOutput("rb_addr", bus.mem_addr, 32'h0);
    checkOutput("rb_wdata", bus.mem_wdata, 32'h0);
    checkOutput("rb_resp", {28'h0, bus.ifu_rvalid, bus.ifu_err, bus.lsu_rvalid, bus.lsu_err}, 32'h0);
    checkOutput("rb_ifu_rdata", bus.ifu_rdata, 32'h0);
    checkOutput("rb_lsu_rdata", bus.lsu_rdata, 32'h0);
    nextCycle();
    sample();
    checkOutput("rb_no_rvalid", 32'(bus.ifu_rvalid), 32'h0);
    mem_hang = 1'b0;
    nextCycle();
    applyStimulus(1, 32'h8000_0000, 0, 0, 32'h0, 32'h0, 8'h0);
    ifu_exp.push_back(mk(32'h0000_0413, 1'b0));
    sample();
    checkOutput("rb_regnt", 32'(bus.ifu_gnt), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      nextCycle();
      if (i == 0) applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 8'h0);
      sample();
      seen = bus.ifu_rvalid;
    end
    checkOutput("rb_regnt_resp", 32'(seen), 32'h1);

    // IFU request held continuously: grant and response coincide every other cycle.
    nextCycle();
    mem_latency = 0;
    addr = 32'h8000_4000;
    applyStimulus(1, addr, 0, 0, 32'h0, 32'h0, 8'h0);
    for (int i = 0; i < 8; i++) begin
      sample();
      checkOutput("held_gnt", 32'(bus.ifu_gnt), 32'((i % 2) == 0));
      checkOutput("held_rvalid", 32'(bus.ifu_rvalid), 32'(((i % 2) == 0) && (i > 0)));
      seen = bus.ifu_gnt;
      if (seen) ifu_exp.push_back(mk(read_model(addr), 1'b0));
      nextCycle();
      if (seen) begin
        addr = addr + 32'd4;
        bus.ifu_addr = addr;
      end
    end
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 8'h0);
    repeat (3) nextCycle();

    checkOutput("ifu_queue_empty", 32'(ifu_exp.size()), 32'h0);
    checkOutput("lsu_queue_empty", 32'(lsu_exp.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
